alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Initiator side of the 64-bit registered ALU interface. Accepts tagged operation requests on a valid/ready port and drives the ALU operand/opcode/shift inputs.
- Tracks each request through the ALU's one-cycle latency, then returns result and tag on a valid/ready response port through an internal FIFO.
- Sits between a command source (sequencer or test driver) and the ALU instance. Provides back-pressure so no result is ever dropped.

Parameters:
- DEPTH, 4, response FIFO entries; also the maximum outstanding requests (power of 2, ≥2).
- TAG_W, 4, width of the request/response tag.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  issuer can accept
- req_op  in  4  ALU opcode (0..9 legal)
- req_a  in  64  operand A
- req_b  in  64  operand B
- req_shift  in  5  shift amount
- req_tag  in  TAG_W  request tag
- alu_a  out  64  to ALU A
- alu_b  out  64  to ALU B
- alu_op  out  4  to ALU Op
- alu_shift  out  5  to ALU shift
- alu_reset  out  1  active-high ALU reset, = ~reset (combinational)
- alu_out  in  64  ALU registered result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_data  out  64  result
- rsp_tag  out  TAG_W  tag of the result
- rsp_err  out  1  illegal opcode flag (see Optional Feature)

Behaviour:
- Reset is sampled on posedge clk with reset==0. It clears alu_a, alu_b, alu_op, alu_shift, s1_valid, s2_valid, FIFO pointers and count. After reset: rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, req_ready=1.
- Reset mid-operation discards all in-flight and queued results. No response is produced for them.
- Acceptance: req_valid && req_ready at edge k.
- At edge k, req_a, req_b, req_op and req_shift load into alu_*. The tag and error bit load into stage 1, and s1_valid is set.
- At edge k+1, the ALU registers its result. Stage 1 moves to stage 2 (s2_valid, s2_tag, s2_err).
- At edge k+2, {alu_out, s2_tag, s2_err} is written to the FIFO.
- rsp_valid is high after edge k+2 if the FIFO was empty. Fixed accept-to-rsp_valid latency is 2 edges; there is no bypass.
- alu_* hold their last value when nothing is accepted. The held value is harmless because stage valids gate FIFO writes.
- Credits: occupancy = fifo_count + s1_valid + s2_valid.
  - req_ready = (occupancy < DEPTH), computed from registered state only, with no combinational path from req_valid or rsp_ready.
  - A pop at edge k frees a credit visible after edge k.
  - Because of credits, a FIFO write never meets a full FIFO. Overflow is a design error; the bench asserts it never happens.
- FIFO: pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
  - rsp_data, rsp_tag and rsp_err show the head entry and are stable while rsp_valid && !rsp_ready.
- Back-to-back: one request per cycle is sustainable while rsp_ready stays high. Responses return in request order.
- Full: with rsp_ready low, exactly DEPTH requests are accepted, then req_ready=0 until the first pop.

Optional Feature:
- Macro ALU_ILLEGAL_OP_ERR_EN.
- Defined: a request with req_op > 9 is still issued. Its response carries rsp_err=1 and rsp_data=0 (forced, independent of alu_out).
- Undefined: rsp_err is tied to 0, no error bit is stored in the FIFO, and rsp_data passes alu_out unchanged.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SHL=4, OP_SHR=5, OP_XNOR=6, OP_EQ=7, OP_LT=8, OP_GT=9
  - OP_LAST=9
  - DATA_W=64, SHAMT_W=5
- Sub-module alu_rsp_fifo: synchronous FIFO, parameterised width/depth, with count output. Reused by later blocks.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-traffic → rsp_valid=0, req_ready=1, alu_op=0, and no stale responses afterwards.
- Single ADD: A=64'h5, B=64'h7, tag=3 accepted at edge k → rsp_valid after edge k+2 with rsp_data=12 and rsp_tag=3.
- Back-to-back: SUB(10,3) tag 1, SHL(1, shift 63→5-bit 31) tag 2, and LT(2,9) tag 3, with rsp_ready=1 → responses 7, 64'h8000_0000, 1 in order on consecutive cycles.
- Full/back-pressure: rsp_ready=0 and 6 requests offered → exactly 4 accepted and req_ready=0. Raising rsp_ready drains tags 0..3, and req_ready reasserts one cycle after the first pop.
- Simultaneous push/pop at steady state with FIFO count 2 → count stays 2 and the data order is preserved.
- Illegal op 4'hC, A=B=1, with ALU_ILLEGAL_OP_ERR_EN defined → rsp_err=1 and rsp_data=0. With it undefined → rsp_err=0 and rsp_data=alu_out (0).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 64-bit registered ALU and the blocks that drive it.
package alu_pkg;

  localparam int DATA_W  = 64;
  localparam int SHAMT_W = 5;
  localparam int OP_W    = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd4;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 4'd6;
  localparam logic [OP_W-1:0] OP_EQ   = 4'd7;
  localparam logic [OP_W-1:0] OP_LT   = 4'd8;
  localparam logic [OP_W-1:0] OP_GT   = 4'd9;
  localparam logic [OP_W-1:0] OP_LAST = OP_GT;

  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return op > OP_LAST;
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous FIFO with occupancy count; head entry is presented combinationally.
module alu_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues tagged requests to a one-cycle registered ALU and queues results with credit flow control.
// Optional illegal-opcode flagging is enabled by defining ALU_ILLEGAL_OP_ERR_EN.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic [63:0]        req_a,
  input  logic [63:0]        req_b,
  input  logic [4:0]         req_shift,
  input  logic [TAG_W-1:0]   req_tag,
  output logic [63:0]        alu_a,
  output logic [63:0]        alu_b,
  output logic [3:0]         alu_op,
  output logic [4:0]         alu_shift,
  output logic               alu_reset,
  input  logic [63:0]        alu_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [63:0]        rsp_data,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
`ifdef ALU_ILLEGAL_OP_ERR_EN
  localparam int FIFO_W = DATA_W + TAG_W + 1;
`else
  localparam int FIFO_W = DATA_W + TAG_W;
`endif

  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic [SHAMT_W-1:0] alu_shift_q, alu_shift_d;
  logic               s1_valid_q, s1_valid_d;
  logic               s2_valid_q, s2_valid_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

  logic [CNT_W-1:0]   fifo_count;
  logic [OCC_W-1:0]   occupancy;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               accept;
  logic [FIFO_W-1:0]  fifo_wdata;
  logic [FIFO_W-1:0]  fifo_rdata;
  logic [TAG_W-1:0]   head_tag;

  // Every in-flight request already owns a FIFO slot, so a push can never overflow.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q);
  assign req_ready = (occupancy < OCC_W'(DEPTH));
  assign accept    = req_valid && req_ready;

  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_shift_d = alu_shift_q;
    s1_tag_d    = s1_tag_q;
    s1_valid_d  = accept;
    if (accept) begin
      alu_a_d     = req_a;
      alu_b_d     = req_b;
      alu_op_d    = req_op;
      alu_shift_d = req_shift;
      s1_tag_d    = req_tag;
    end
    s2_valid_d = s1_valid_q;
    s2_tag_d   = s1_tag_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_shift_q <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s2_tag_q    <= '0;
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_shift_q <= alu_shift_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s1_tag_q    <= s1_tag_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

`ifdef ALU_ILLEGAL_OP_ERR_EN
  logic s1_err_q, s1_err_d;
  logic s2_err_q, s2_err_d;

  always_comb begin
    s1_err_d = s1_err_q;
    if (accept) begin
      s1_err_d = op_is_illegal(req_op);
    end
    s2_err_d = s1_err_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_err_q <= 1'b0;
      s2_err_q <= 1'b0;
    end else begin
      s1_err_q <= s1_err_d;
      s2_err_q <= s2_err_d;
    end
  end

  // Illegal requests still flow through the ALU, but their data is forced to zero.
  assign fifo_wdata = {(s2_err_q ? {DATA_W{1'b0}} : alu_out), s2_tag_q, s2_err_q};
  assign head_tag   = fifo_rdata[TAG_W:1];
  assign rsp_err    = rsp_valid && fifo_rdata[0];
`else
  assign fifo_wdata = {alu_out, s2_tag_q};
  assign head_tag   = fifo_rdata[TAG_W-1:0];
  assign rsp_err    = 1'b0;
`endif

  alu_rsp_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s2_valid_q),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head_data (fifo_rdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign fifo_pop  = rsp_valid && rsp_ready;
  // Storage is not reset, so the response fields read zero whenever nothing is queued.
  assign rsp_data  = rsp_valid ? fifo_rdata[FIFO_W-1 -: DATA_W] : '0;
  assign rsp_tag   = rsp_valid ? head_tag : '0;

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_shift = alu_shift_q;
  assign alu_reset = ~reset;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural ALU stub; honours ALU_ILLEGAL_OP_ERR_EN.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [63:0]       req_a;
  logic [63:0]       req_b;
  logic [4:0]        req_shift;
  logic [TAG_W-1:0]  req_tag;
  logic [63:0]       alu_a;
  logic [63:0]       alu_b;
  logic [3:0]        alu_op;
  logic [4:0]        alu_shift;
  logic              alu_reset;
  logic [63:0]       alu_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shift(req_shift), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shift(alu_shift),
    .alu_reset(alu_reset), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic [4:0] sh);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SHL:  return a << sh;
      OP_SHR:  return a >> sh;
      OP_XNOR: return ~(a ^ b);
      OP_EQ:   return (a == b) ? 64'd1 : 64'd0;
      OP_LT:   return (a < b) ? 64'd1 : 64'd0;
      OP_GT:   return (a > b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  // Registered ALU model with one cycle of latency.
  always @(posedge clk) begin
    if (alu_reset) alu_out <= '0;
    else           alu_out <= alu_ref(alu_op, alu_a, alu_b, alu_shift);
  end

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
    logic             err;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   cycle = 0;
  logic rst_edge = 1'b0;
  bit   mon_en = 1'b0;

  always @(posedge clk) begin
    cycle    <= cycle + 1;
    rst_edge <= !reset;
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Monitor: outstanding requests (accepted at an edge already passed) determine req_ready;
  // the oldest one becomes visible two edges after its acceptance.
  always @(negedge clk) begin : mon
    int outst;
    bit head_ok;
    if (mon_en) begin
      outst = 0;
      foreach (sb[i]) if (sb[i].acc <= cycle) outst++;
      head_ok = (sb.size() > 0) && (sb[0].acc + 2 <= cycle);
      chk(outst <= DEPTH, "overflow", 64'(outst), 64'(DEPTH));
      chk(req_ready == (outst < DEPTH), "req_ready", 64'(req_ready), 64'(outst < DEPTH));
      chk(rsp_valid == head_ok, "rsp_valid", 64'(rsp_valid), 64'(head_ok));
      if (head_ok && rsp_valid) begin
        chk(rsp_data == sb[0].data, "rsp_data", rsp_data, sb[0].data);
        chk(rsp_tag == sb[0].tag, "rsp_tag", 64'(rsp_tag), 64'(sb[0].tag));
        chk(rsp_err == sb[0].err, "rsp_err", 64'(rsp_err), 64'(sb[0].err));
        if (rsp_ready) begin
          $display("rsp cycle=%0d tag=%0d data=%h err=%0b", cycle, rsp_tag, rsp_data, rsp_err);
          void'(sb.pop_front());
        end
      end
      if (rst_edge) begin
        chk(alu_op == 4'd0, "reset_alu_op", 64'(alu_op), 64'd0);
        chk(rsp_data == 64'd0, "reset_rsp_data", rsp_data, 64'd0);
        chk(rsp_tag == '0, "reset_rsp_tag", 64'(rsp_tag), 64'd0);
        chk(rsp_err == 1'b0, "reset_rsp_err", 64'(rsp_err), 64'd0);
      end
      if (!reset) sb.delete();
    end
  end

  // One clock of driving: acceptance is decided from stable values before the edge.
  task automatic tick();
    exp_t e;
    bit   acc;
    bit   ill;
    @(negedge clk);
    acc = 1'b0;
    if (reset && req_valid && req_ready) begin
`ifdef ALU_ILLEGAL_OP_ERR_EN
      ill = (req_op > 4'd9);
`else
      ill = 1'b0;
`endif
      e.tag  = req_tag;
      e.err  = ill;
      e.data = ill ? 64'd0 : alu_ref(req_op, req_a, req_b, req_shift);
      e.acc  = cycle + 1;
      sb.push_back(e);
      n_acc++;
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
    if (acc) req_valid = 1'b0;
  endtask

  task automatic load(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] sh, input logic [TAG_W-1:0] tag);
    req_op = op; req_a = a; req_b = b; req_shift = sh; req_tag = tag;
    req_valid = 1'b1;
  endtask

  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] sh, input logic [TAG_W-1:0] tag);
    load(op, a, b, sh, tag);
    for (int i = 0; i < 50 && req_valid; i++) tick();
    chk(!req_valid, "send_timeout", 64'(req_valid), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_random();
    load(4'($urandom_range(0, 11)), {$urandom, $urandom},
         ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom},
         5'($urandom_range(0, 31)), TAG_W'($urandom_range(0, 15)));
  endtask

  initial begin
    int idx;
    int acc0;
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = '0; req_a = '0; req_b = '0; req_shift = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    reset  = 1'b1;

    // Single ADD
    send(OP_ADD, 64'h5, 64'h7, 5'd0, 4'd3);
    idle(4);

    // Back-to-back
    send(OP_SUB, 64'd10, 64'd3, 5'd0, 4'd1);
    send(OP_SHL, 64'd1, 64'd0, 5'd31, 4'd2);
    send(OP_LT, 64'd2, 64'd9, 5'd0, 4'd3);
    idle(5);

    // Full: six offered with no consumer, exactly DEPTH accepted
    rsp_ready = 1'b0;
    acc0 = n_acc;
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      if (!req_valid && idx < 6) begin
        load(OP_ADD, 64'(idx), 64'd100, 5'd0, TAG_W'(idx));
        idx++;
      end
      tick();
    end
    chk(n_acc - acc0 == DEPTH, "full_accepts", 64'(n_acc - acc0), 64'(DEPTH));
    chk(req_ready == 1'b0, "full_ready", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && (idx < 6 || req_valid); i++) begin
      if (!req_valid && idx < 6) begin
        load(OP_ADD, 64'(idx), 64'd100, 5'd0, TAG_W'(idx));
        idx++;
      end
      tick();
    end
    chk(n_acc - acc0 == 6, "full_total", 64'(n_acc - acc0), 64'd6);
    idle(8);

    // Two results parked in the FIFO, then push and pop together
    rsp_ready = 1'b0;
    send(OP_XNOR, 64'hF0, 64'h0F, 5'd0, 4'd8);
    send(OP_OR, 64'hA0, 64'h05, 5'd0, 4'd9);
    idle(3);
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (!req_valid) load(OP_SHR, 64'hFF00, 64'd0, 5'(i), TAG_W'(i));
      tick();
    end
    while (req_valid) tick();
    idle(6);

    // Illegal opcode
    send(4'hC, 64'd1, 64'd1, 5'd0, 4'd5);
    idle(5);

    // Random traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid && $urandom_range(0, 2) != 0) load_random();
      tick();
    end

    // Drain
    for (int i = 0; i < 50 && req_valid; i++) tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    chk(sb.size() == 0, "drain_timeout", 64'(sb.size()), 64'd0);
    idle(2);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
